// File: rtl/slave_axi_writer_if.sv
// AXI3 read-side bus bundle: AR and R channels.
// The master modport drives requests, the slave answers.
interface slave_axi_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize,
    output arburst, arvalid, rready,
    input  arready, rid, rdata, rresp,
    input  rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize,
    input  arburst, arvalid, rready,
    output arready, rid, rdata, rresp,
    output rlast, rvalid
  );
endinterface

// File: rtl/slave_axi_writer.sv
// AXI3 read-channel slave: AR capture, per-beat address
// generation toward the engine, 2-deep credited R buffer.
module slave_axi_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  slave_axi_writer_if.slave     axi,
  input  logic                  eng_start,
  output logic                  busy,
  output logic                  done,
  output logic                  beat_req_valid,
  input  logic                  beat_req_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [2:0]            beat_size,
  input  logic                  beat_rsp_valid,
  input  logic [DATA_WIDTH-1:0] beat_rsp_data,
  input  logic                  beat_rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_AR, S_ISSUE, S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [4:0]            req_cnt_q;
  logic [4:0]            rsp_cnt_q;
  logic [1:0]            credits_q;

  logic [DATA_WIDTH-1:0] fd_q [2];
  logic [1:0]            fr_q [2];
  logic                  fl_q [2];
  logic                  wp_q, rp_q;
  logic [1:0]            cnt_q;

  logic rsvd, can_issue, issue, last_issue;
  logic ar_fire, push, pop, head_last;
  logic arready_c, req_valid_c, busy_c, done_c;
  logic [ADDR_WIDTH-1:0] bytes, span, smask;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            push_resp;
  logic                  push_last, wrap_ok;

  assign rsvd      = (burst_q == 2'b11);
  assign can_issue = (state_q == S_ISSUE)
                   && (req_cnt_q <= {1'b0, len_q})
                   && (credits_q < 2'd2);
  assign ar_fire   = (state_q == S_AR) && axi.arvalid;
  assign pop       = axi.rvalid && axi.rready;
  assign head_last = fl_q[rp_q];

  // Engine responses only count once a burst is being served.
  assign push = rsvd
    ? can_issue
    : beat_rsp_valid
      && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  assign issue      = rsvd ? can_issue
                           : (req_valid_c && beat_req_ready);
  assign last_issue = issue
                   && (req_cnt_q == {1'b0, len_q});

  assign push_data = rsvd ? '0 : beat_rsp_data;
  assign push_resp = (rsvd || beat_rsp_err) ? 2'b10
                                            : 2'b00;
  assign push_last = (rsp_cnt_q == {1'b0, len_q});

  assign bytes   = ADDR_WIDTH'(1) << size_q;
  assign span    = (ADDR_WIDTH'(len_q) + 1'b1) << size_q;
  assign smask   = span - 1'b1;
  assign wrap_ok = (burst_q == 2'b10)
                && ((len_q == 4'd1) || (len_q == 4'd3)
                 || (len_q == 4'd7) || (len_q == 4'd15));

  // Next beat address for FIXED, WRAP and INCR bursts.
  always_comb begin
    addr_d = addr_q;
    unique case (1'b1)
      (burst_q == 2'b00): addr_d = addr_q;
      wrap_ok: addr_d = (addr_q & ~smask)
                      | ((addr_q + bytes) & smask);
      default: addr_d = (addr_q & ~(bytes - 1'b1))
                      + bytes;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (eng_start)  state_d = S_AR;
      S_AR:    if (axi.arvalid) state_d = S_ISSUE;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (done_c)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state outputs.
  always_comb begin
    arready_c   = 1'b0;
    req_valid_c = 1'b0;
    busy_c      = (state_q != S_IDLE);
    done_c      = 1'b0;
    case (state_q)
      S_AR:    arready_c   = 1'b1;
      S_ISSUE: req_valid_c = can_issue && !rsvd;
      S_DRAIN: done_c      = pop && head_last;
      default: ;
    endcase
  end

  // Burst context, beat counters and credits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      credits_q <= '0;
    end else begin
      if (ar_fire) begin
        id_q      <= axi.arid;
        addr_q    <= axi.araddr;
        len_q     <= axi.arlen;
        size_q    <= axi.arsize;
        burst_q   <= axi.arburst;
        req_cnt_q <= '0;
        rsp_cnt_q <= '0;
      end else begin
        if (issue) begin
          req_cnt_q <= req_cnt_q + 5'd1;
          addr_q    <= addr_d;
        end
        if (push) rsp_cnt_q <= rsp_cnt_q + 5'd1;
      end
      case ({issue, pop})
        2'b10:   credits_q <= credits_q + 2'd1;
        2'b01:   credits_q <= credits_q - 2'd1;
        default: credits_q <= credits_q;
      endcase
    end
  end

  // Two-entry return buffer feeding the R channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fd_q[i] <= '0;
        fr_q[i] <= '0;
        fl_q[i] <= 1'b0;
      end
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fd_q[wp_q] <= push_data;
        fr_q[wp_q] <= push_resp;
        fl_q[wp_q] <= push_last;
        wp_q       <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Credits must keep the buffer from ever overflowing.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && (cnt_q == 2'd2))
  );

  assign axi.arready   = arready_c;
  assign axi.rvalid    = (cnt_q != 2'd0);
  assign axi.rdata     = fd_q[rp_q];
  assign axi.rresp     = fr_q[rp_q];
  assign axi.rlast     = fl_q[rp_q];
  assign axi.rid       = id_q;
  assign busy          = busy_c;
  assign done          = done_c;
  assign beat_req_valid = req_valid_c;
  assign beat_addr     = addr_q;
  assign beat_size     = size_q;

endmodule

// File: tb/tb_slave_axi_writer.sv
// Scoreboard bench for slave_axi_writer: engine model,
// expected beat addresses and R beats checked in order.
module tb_slave_axi_writer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slave_axi_writer_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) axi ();

  logic          eng_start;
  logic          busy, done;
  logic          beat_req_valid, beat_req_ready;
  logic [AW-1:0] beat_addr;
  logic [2:0]    beat_size;
  logic          beat_rsp_valid;
  logic [DW-1:0] beat_rsp_data;
  logic          beat_rsp_err;

  slave_axi_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .axi            (axi.slave),
    .eng_start      (eng_start),
    .busy           (busy),
    .done           (done),
    .beat_req_valid (beat_req_valid),
    .beat_req_ready (beat_req_ready),
    .beat_addr      (beat_addr),
    .beat_size      (beat_size),
    .beat_rsp_valid (beat_rsp_valid),
    .beat_rsp_data  (beat_rsp_data),
    .beat_rsp_err   (beat_rsp_err)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } rbeat_t;

  int n_chk = 0;
  int n_err = 0;

  logic [AW-1:0] exp_addr_q [$];
  rbeat_t        exp_r_q [$];

  logic [IW-1:0] cur_id;
  logic [3:0]    cur_len;
  logic [2:0]    cur_size;
  bit            cur_rsvd;
  int            err_beat;
  int            req_idx, rsp_idx;
  int            issued, popped;
  bit            done_seen;

  logic          pend_v, pend_err;
  logic [DW-1:0] pend_data;
  bit            stall_prev;
  logic [DW+2:0] stall_val;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Engine model and output monitor, away from the edge.
  always @(negedge clk) begin
    if (rst) begin
      pend_v         = 1'b0;
      beat_rsp_valid = 1'b0;
      beat_rsp_err   = 1'b0;
      beat_rsp_data  = '0;
      stall_prev     = 1'b0;
    end else begin
      beat_rsp_valid = pend_v;
      beat_rsp_data  = pend_v ? pend_data : '0;
      beat_rsp_err   = pend_v && pend_err;
      if (pend_v) begin
        exp_r_q.push_back(rbeat_t'{
          cur_id, pend_data,
          pend_err ? 2'b10 : 2'b00,
          rsp_idx == int'(cur_len)});
        rsp_idx++;
      end
      pend_v = 1'b0;

      if (!cur_rsvd && (issued - popped == 2))
        chk("credit_block", beat_req_valid, 0);
      if (beat_req_valid && beat_req_ready) begin
        if (exp_addr_q.size() == 0)
          chk("req_extra", 1, 0);
        else
          chk("beat_addr", beat_addr,
              exp_addr_q.pop_front());
        chk("beat_size", beat_size, cur_size);
        pend_v    = 1'b1;
        pend_data = $urandom;
        pend_err  = (req_idx == err_beat);
        req_idx++;
        issued++;
      end

      if (stall_prev && axi.rvalid)
        chk("r_hold",
            {axi.rdata, axi.rresp, axi.rlast},
            stall_val);
      stall_prev = axi.rvalid && !axi.rready;
      stall_val  = {axi.rdata, axi.rresp, axi.rlast};

      if (axi.rvalid && axi.rready) begin
        if (exp_r_q.size() == 0) begin
          chk("r_extra", 1, 0);
        end else begin
          rbeat_t e;
          e = exp_r_q.pop_front();
          chk("rid",   axi.rid,   e.id);
          chk("rdata", axi.rdata, e.data);
          chk("rresp", axi.rresp, e.resp);
          chk("rlast", axi.rlast, e.last);
          chk("done",  done,      e.last);
          if (e.last) done_seen = 1'b1;
        end
        popped++;
      end else begin
        chk("done_idle", done, 0);
      end
    end
  end

  task automatic start_burst(
    input logic [IW-1:0] id,
    input logic [AW-1:0] addr,
    input logic [3:0]    len,
    input logic [2:0]    size,
    input logic [1:0]    burst,
    input int            err_b,
    input bit            hold_r
  );
    logic [AW-1:0] bytes, span, base, a;
    bit wrapok, ok;
    bytes  = AW'(1) << size;
    span   = bytes * (AW'(len) + 1);
    base   = (addr / span) * span;
    wrapok = (burst == 2'b10) &&
             (len == 1 || len == 3 ||
              len == 7 || len == 15);
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'b11)
        exp_r_q.push_back(rbeat_t'{
          id, '0, 2'b10, i == int'(len)});
      else begin
        if (i == 0 || burst == 2'b00)
          a = addr;
        else if (wrapok)
          a = base + ((addr - base +
                       AW'(i) * bytes) % span);
        else
          a = (addr / bytes) * bytes +
              AW'(i) * bytes;
        exp_addr_q.push_back(a);
      end
    end
    cur_id    = id;
    cur_len   = len;
    cur_size  = size;
    cur_rsvd  = (burst == 2'b11);
    err_beat  = err_b;
    req_idx   = 0;
    rsp_idx   = 0;
    issued    = 0;
    popped    = 0;
    done_seen = 1'b0;
    axi.rready  = !hold_r;
    axi.arid    = id;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = burst;
    axi.arvalid = 1'b1;
    eng_start   = 1'b1;
    @(negedge clk);
    chk("arready_idle", axi.arready, 0);
    @(posedge clk); #1;
    eng_start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (axi.arready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ar_handshake", ok, 1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    @(negedge clk);
    chk("req_latency", beat_req_valid, !cur_rsvd);
  endtask

  task automatic finish_burst(input int stall);
    bit ok;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 axi.rready = 1'b1;
    end
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (done_seen) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", ok, 1);
    #1;
    chk("busy_end", busy, 0);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("r_q_empty", exp_r_q.size(), 0);
  endtask

  task automatic run_burst(
    input logic [IW-1:0] id,
    input logic [AW-1:0] addr,
    input logic [3:0]    len,
    input logic [2:0]    size,
    input logic [1:0]    burst,
    input int            err_b,
    input int            stall
  );
    start_burst(id, addr, len, size, burst,
                err_b, stall > 0);
    finish_burst(stall);
  endtask

  initial begin
    rst            = 1'b1;
    eng_start      = 1'b0;
    beat_req_ready = 1'b1;
    axi.arid       = '0;
    axi.araddr     = '0;
    axi.arlen      = '0;
    axi.arsize     = '0;
    axi.arburst    = '0;
    axi.arvalid    = 1'b0;
    axi.rready     = 1'b1;
    cur_id = '0; cur_len = '0; cur_size = '0;
    cur_rsvd = 1'b0; err_beat = -1;
    req_idx = 0; rsp_idx = 0;
    issued = 0; popped = 0; done_seen = 1'b0;
    #22;
    chk("rst_arready", axi.arready, 0);
    chk("rst_rvalid",  axi.rvalid,  0);
    chk("rst_rlast",   axi.rlast,   0);
    chk("rst_rresp",   axi.rresp,   0);
    chk("rst_rdata",   axi.rdata,   0);
    chk("rst_rid",     axi.rid,     0);
    chk("rst_reqv",    beat_req_valid, 0);
    chk("rst_baddr",   beat_addr,   0);
    chk("rst_bsize",   beat_size,   0);
    chk("rst_busy",    busy,        0);
    chk("rst_done",    done,        0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    run_burst(4'h5, 32'h1000, 4'd3, 3'd2,
              2'b01, -1, 0);
    run_burst(4'h6, 32'h2008, 4'd3, 3'd2,
              2'b10, -1, 0);
    run_burst(4'h7, 32'h0030, 4'd2, 3'd2,
              2'b00, -1, 0);
    run_burst(4'h8, 32'h4000, 4'd7, 3'd2,
              2'b01, -1, 10);
    run_burst(4'h9, 32'h0400, 4'd2, 3'd2,
              2'b01, 1, 0);
    run_burst(4'hA, 32'h0500, 4'd1, 3'd2,
              2'b11, -1, 0);
    run_burst(4'hB, 32'h0040, 4'd2, 3'd2,
              2'b10, -1, 0);
    run_burst(4'hC, 32'hFFFF_FFFC, 4'd1, 3'd2,
              2'b01, -1, 0);

    start_burst(4'h3, 32'h5000, 4'd7, 3'd2,
                2'b01, -1, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_rvalid", axi.rvalid, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rvalid",  axi.rvalid,  0);
    chk("mid_rst_arready", axi.arready, 0);
    chk("mid_rst_busy",    busy,        0);
    chk("mid_rst_reqv",    beat_req_valid, 0);
    exp_addr_q.delete();
    exp_r_q.delete();
    issued = 0;
    popped = 0;
    axi.rready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    run_burst(4'hD, 32'h6000, 4'd3, 3'd2,
              2'b01, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/slave_axi_writer.md
Name: slave_axi_writer

Overview:
- Read-channel counterpart of the bridge's AXI slave write-channel receiver: accepts AXI3 read addresses (AR) and returns read data (R) to the AXI master.
- Between the two channels it generates per-beat addresses (FIXED/INCR/WRAP) and issues them to the bridge engine, which performs the APB reads.
- A 2-entry credit-controlled buffer decouples engine return data from R-channel backpressure.

Parameters:
ADDR_WIDTH, 32, AXI/APB address width
DATA_WIDTH, 32, AXI data width (bytes per beat at most DATA_WIDTH/8)
ID_WIDTH, 4, AXI ID width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
arid  in  ID_WIDTH  read address ID
araddr  in  ADDR_WIDTH  burst start address
arlen  in  4  beats-1
arsize  in  3  log2 bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  captured arid
rdata  out  DATA_WIDTH  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
eng_start  in  1  engine grants a new read burst
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse when the last R beat is accepted
beat_req_valid  out  1  beat read request to engine
beat_req_ready  in  1  engine accepts request
beat_addr  out  ADDR_WIDTH  beat address
beat_size  out  3  captured arsize
beat_rsp_valid  in  1  engine returns one beat, no backpressure
beat_rsp_data  in  DATA_WIDTH  returned data
beat_rsp_err  in  1  APB PSLVERR for the beat

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty, credits=0, beat counters=0. All outputs are 0: arready, rvalid, rlast, rresp, rdata, rid, beat_req_valid, beat_addr, beat_size, busy, done.
- State machine:
  - IDLE -> AR when eng_start=1.
  - AR: arready=1. On arvalid, capture id/addr/len/size/burst and set req_cnt=0, rsp_cnt=0, then go to ISSUE.
  - ISSUE: beat_req_valid=1 while req_cnt<=len and credits<2. When beat_req_valid&beat_req_ready: req_cnt++, credits++, beat_addr advances. After the last request is accepted, go to DRAIN.
  - DRAIN: wait for the last beat. On rvalid&rready&rlast, done=1 that cycle and go to IDLE the next cycle.
- Latency:
  - AR handshake in cycle N -> beat_req_valid is first high in N+1.
  - beat_rsp_valid in cycle M -> rvalid high in M+1 (registered FIFO output).
- Credits:
  - credits = requests issued minus beats popped from R. Push increments nothing; issue +1; R pop -1; issue and pop in the same cycle leave credits unchanged.
  - This guarantees a push never finds the FIFO full.
  - A push while full is an assertion failure.
- FIFO: depth 2, each entry holds {data, resp, last}.
  - last is set when rsp_cnt==len at push.
  - resp = beat_rsp_err ? 2'b10 : 2'b00.
  - Push and pop in the same cycle with 1 entry leave 1 entry, holding the new data.
- R channel:
  - rvalid = FIFO not empty; rdata/rresp/rlast come from the head entry.
  - All R outputs are held stable while rvalid&!rready.
  - rid = captured id for the whole burst.
- Address generation (bytes = 1<<size). First beat_addr = araddr unaligned as given; later beats are aligned to bytes.
  - FIXED: every beat uses araddr.
  - INCR: next = aligned(addr)+bytes, width ADDR_WIDTH with natural wrap at 2^ADDR_WIDTH.
  - WRAP: span = (len+1)*bytes; base = addr & ~(span-1); next = base | ((addr+bytes) & (span-1)). Legal len is 1, 3, 7 or 15. Any other len is treated as INCR.
- Reserved burst (11):
  - No engine requests are issued (beat_req_valid stays 0).
  - The block returns len+1 beats directly into the FIFO with rdata=0 and rresp=2'b10.
  - The same credit limit of 2 applies.
- Hazards:
  - arvalid outside the AR state is ignored (arready=0).
  - beat_rsp_valid while in IDLE/AR is ignored.
- Reset mid-burst returns to IDLE immediately. The R channel drops with no rlast, and the engine is reset by the same rst.

Test Plan:
- INCR, araddr=0x1000, arlen=3, arsize=2, rready=1, engine 1-cycle turnaround -> beat_addr 0x1000, 0x1004, 0x1008, 0x100C; 4 R beats with rid=arid, rlast only on the 4th, done pulse on the same cycle as the rlast handshake.
- WRAP, araddr=0x2008, arlen=3, arsize=2 -> beat_addr 0x2008, 0x200C, 0x2000, 0x2004.
- FIXED, arlen=2, araddr=0x30 -> three requests, all to 0x30.
- INCR arlen=7 with rready low for 10 cycles -> at most 2 requests outstanding, beat_req_valid=0 while credits==2, rdata/rlast stable while stalled, no data lost, 8 beats in order.
- beat_rsp_err=1 on beat 1 of 3 -> rresp 00, 10, 00.
- arburst=2'b11, arlen=1 -> no beat_req_valid, 2 beats with rdata=0, rresp=10, rlast on beat 2.
- Async rst asserted mid-burst (between clock edges) -> rvalid, arready and busy go to 0 immediately. After release: eng_start then a new AR -> correct fresh burst.
